cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the CPU core. It replaces the free-running program counter and fixed-latency memory hookup with a parametrised FSM that walks each instruction through fetch, decode, execute, memory and writeback. Instruction and data memory use variable-latency req/ack handshakes, with a bus timeout that raises a fault. It sits between the instruction/data memories and the existing decoder, ALU and register file, and owns the PC, the instruction register and the retired-instruction count.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/bus_watchdog.sv | 39 +++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IF    = 3'd1,
        ST_ID    = 3'd2,
        ST_EX    = 3'd3,
        ST_MEM   = 3'd4,
        ST_WB    = 3'd5,
        ST_HALT  = 3'd6,
        ST_FAULT = 3'd7
    } state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int unsigned PC_STEP  = 4;

endpackage

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for memory handshakes; flags when an ack is overdue.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive cycles spent waiting; cleared outside the wait states.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The TIMEOUT-th cycle without ack is the last one tolerated; an ack in it still wins.
    assign expired = waiting && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer owning pc, ir and retire count.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter int unsigned          TIMEOUT  = 16,
    parameter int unsigned          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    input  logic              dec_reg_we,
    input  logic              dec_is_load,
    input  logic              dec_is_store,
    input  logic              dec_is_halt,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              br_taken,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    input  logic              dmem_ack,
    output logic              rf_we,
    output logic [XLEN-1:0]   pc,
    output logic              halted,
    output logic              bus_err,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   daddr_q, daddr_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic              wd_clear, wd_waiting, wd_expired;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .waiting (wd_waiting),
        .expired (wd_expired)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSN;
            daddr_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            daddr_q <= daddr_d;
            ret_q   <= ret_d;
        end
    end

    // Next-state selection; an ack takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_IF;
            ST_IF: begin
                if (imem_ack)        state_d = ST_ID;
                else if (wd_expired) state_d = ST_FAULT;
            end
            ST_ID:    state_d = dec_is_halt ? ST_HALT : ST_EX;
            ST_EX:    state_d = (dec_is_load || dec_is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack)        state_d = ST_WB;
                else if (wd_expired) state_d = ST_FAULT;
            end
            ST_WB:    state_d = ST_IF;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath updates: instruction latch, memory address, pc advance and retire count.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        daddr_d = daddr_q;
        ret_d   = ret_q;
        case (state_q)
            ST_IF: begin
                if (imem_ack) ir_d = imem_rdata;
            end
            ST_ID: begin
                if (dec_is_halt) ret_d = ret_q + CNT_W'(1);
            end
            ST_EX: begin
                daddr_d = alu_result;
            end
            ST_WB: begin
                pc_d  = br_taken ? {alu_result[XLEN-1:1], 1'b0} : pc_q + XLEN'(PC_STEP);
                ret_d = ret_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        imem_req   = (state_q == ST_IF);
        dmem_req   = (state_q == ST_MEM);
        dmem_we    = (state_q == ST_MEM) && dec_is_store;
        rf_we      = (state_q == ST_WB) && dec_reg_we;
        halted     = (state_q == ST_HALT);
        bus_err    = (state_q == ST_FAULT);
        wd_clear   = !((state_q == ST_IF) || (state_q == ST_MEM));
        wd_waiting = ((state_q == ST_IF) && !imem_ack) || ((state_q == ST_MEM) && !dmem_ack);
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign dmem_addr = daddr_q;
    assign retired   = ret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: expands instruction-level descriptions into expected per-cycle behaviour.
module tb_cpu_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, halted, bus_err;
    logic [31:0] imem_addr, imem_rdata, ir, alu_result, dmem_addr, pc, retired;
    logic        dec_reg_we, dec_is_load, dec_is_store, dec_is_halt, br_taken;

    cpu_sequencer #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .TIMEOUT  (16),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .dec_reg_we   (dec_reg_we),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_is_halt  (dec_is_halt),
        .alu_result   (alu_result),
        .br_taken     (br_taken),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_ack     (dmem_ack),
        .rf_we        (rf_we),
        .pc           (pc),
        .halted       (halted),
        .bus_err      (bus_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic        reg_we, ld, st, hlt, br;
        logic [31:0] alu;
        int          iw;   // imem wait cycles before ack; negative = never acks
        int          dw;   // dmem wait cycles before ack
    } instr_t;

    typedef struct {
        logic        iack, dack;
        logic [31:0] rdata;
        instr_t      I;
        logic        e_ireq, e_dreq, e_dwe, e_rfwe, e_halt, e_err;
        logic [31:0] e_pc, e_ir, e_da, e_ret;
    } cyc_t;

    cyc_t        q[$];
    instr_t      prog[$];
    cyc_t        exp_c;
    logic        chk_en = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Architectural model state
    logic [31:0] m_pc, m_ir, m_da, m_ret;

    // Observed event tracking
    int          rise[$];
    int          first_rf, first_err, dreq_cnt;
    logic        prev_ireq;

    function automatic instr_t mk(input logic [31:0] insn, input logic reg_we, ld, st, hlt, br,
                                  input logic [31:0] alu, input int iw, input int dw);
        instr_t r;
        r.insn = insn; r.reg_we = reg_we; r.ld = ld; r.st = st; r.hlt = hlt; r.br = br;
        r.alu = alu; r.iw = iw; r.dw = dw;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    task automatic emit(input instr_t I, input logic ia, da, input logic [31:0] rd,
                        input logic ireq, dreq, dwe, rfwe, hlt, err);
        cyc_t c;
        c.iack = ia; c.dack = da; c.rdata = rd; c.I = I;
        c.e_ireq = ireq; c.e_dreq = dreq; c.e_dwe = dwe; c.e_rfwe = rfwe;
        c.e_halt = hlt; c.e_err = err;
        c.e_pc = m_pc; c.e_ir = m_ir; c.e_da = m_da; c.e_ret = m_ret;
        q.push_back(c);
    endtask

    // Expand the program into the cycle-by-cycle trace the sequencer must produce.
    task automatic build(input logic idle_dack);
        instr_t idle_i;
        idle_i = mk(32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        q.delete();
        m_pc = RST_PC; m_ir = NOP; m_da = 32'h0; m_ret = 32'h0;
        emit(idle_i, 1'b0, idle_dack, JUNK, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < prog.size(); n++) begin
            instr_t I;
            I = prog[n];
            if (I.iw < 0) begin
                for (int k = 0; k < 16; k++) emit(I, 1'b0, 1'b0, JUNK, 1, 0, 0, 0, 0, 0);
                for (int k = 0; k < 5; k++) emit(I, k[0], k[0], JUNK, 0, 0, 0, 0, 0, 1);
                return;
            end
            for (int k = 0; k <= I.iw; k++)
                emit(I, (k == I.iw), 1'b0, (k == I.iw) ? I.insn : JUNK, 1, 0, 0, 0, 0, 0);
            m_ir = I.insn;
            emit(I, 1'b0, 1'b1, JUNK, 0, 0, 0, 0, 0, 0);              // decode (stray dmem ack)
            if (I.hlt) begin
                m_ret = m_ret + 1;
                for (int k = 0; k < 5; k++) emit(I, 1'b1, 1'b1, JUNK, 0, 0, 0, 0, 1, 0);
                return;
            end
            emit(I, 1'b1, 1'b0, JUNK, 0, 0, 0, 0, 0, 0);              // execute (stray imem ack)
            m_da = I.alu;
            if (I.ld || I.st)
                for (int k = 0; k <= I.dw; k++)
                    emit(I, 1'b0, (k == I.dw), JUNK, 0, 1, I.st, 0, 0, 0);
            emit(I, 1'b0, 1'b0, JUNK, 0, 0, 0, I.reg_we, 0, 0);       // writeback
            m_pc  = I.br ? {I.alu[31:1], 1'b0} : m_pc + 32'd4;
            m_ret = m_ret + 1;
        end
    endtask

    task automatic clear_track();
        rise.delete();
        first_rf = -1; first_err = -1; dreq_cnt = 0; prev_ireq = 1'b0;
    endtask

    function automatic int rise_at(input int k);
        return (k < rise.size()) ? rise[k] : -1000;
    endfunction

    task automatic hold_reset();
        rst = 1'b1;
        imem_ack = 0; dmem_ack = 0; imem_rdata = JUNK; alu_result = 0;
        dec_reg_we = 0; dec_is_load = 0; dec_is_store = 0; dec_is_halt = 0; br_taken = 0;
        @(posedge clk); #1;
    endtask

    // Drive the trace one cycle at a time, releasing reset at cycle 0.
    task automatic run(input int stop_at);
        clear_track();
        for (int i = 0; i < q.size() && i < stop_at; i++) begin
            @(posedge clk); #1;
            if (i == 0) rst = 1'b0;
            imem_ack     = q[i].iack;
            dmem_ack     = q[i].dack;
            imem_rdata   = q[i].rdata;
            dec_reg_we   = q[i].I.reg_we;
            dec_is_load  = q[i].I.ld;
            dec_is_store = q[i].I.st;
            dec_is_halt  = q[i].I.hlt;
            br_taken     = q[i].I.br;
            alu_result   = q[i].I.alu;
            exp_c        = q[i];
            cyc          = i;
            chk_en       = 1'b1;
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
    endtask

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_c.e_ireq});
            chk("imem_addr", imem_addr, exp_c.e_pc);
            chk("pc", pc, exp_c.e_pc);
            chk("ir", ir, exp_c.e_ir);
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, exp_c.e_dreq});
            if (exp_c.e_dreq) chk("dmem_we", {31'b0, dmem_we}, {31'b0, exp_c.e_dwe});
            chk("dmem_addr", dmem_addr, exp_c.e_da);
            chk("rf_we", {31'b0, rf_we}, {31'b0, exp_c.e_rfwe});
            chk("halted", {31'b0, halted}, {31'b0, exp_c.e_halt});
            chk("bus_err", {31'b0, bus_err}, {31'b0, exp_c.e_err});
            chk("retired", retired, exp_c.e_ret);
            if (imem_req === 1'b1 && prev_ireq !== 1'b1) rise.push_back(cyc);
            if (rf_we === 1'b1 && first_rf < 0) first_rf = cyc;
            if (bus_err === 1'b1 && first_err < 0) first_err = cyc;
            if (dmem_req === 1'b1) dreq_cnt++;
            prev_ireq = imem_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Scenario 1: ALU, store with 3 wait cycles, taken branch, halt.
        hold_reset();
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", ir, NOP);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        prog.delete();
        prog.push_back(mk(32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0));
        prog.push_back(mk(32'h0020_a023, 0, 0, 1, 0, 0, 32'h0000_0100, 0, 3));
        prog.push_back(mk(32'h0400_006f, 1, 0, 0, 0, 1, 32'h0000_0043, 0, 0));
        prog.push_back(mk(32'h0010_0073, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0));
        build(1'b0);
        run(q.size());
        chk("s1_first_ireq_cycle", rise_at(0), 32'd1);
        chk("s1_first_rfwe_cycle", first_rf, 32'd4);
        chk("s1_alu_len", rise_at(1) - rise_at(0), 32'd4);
        chk("s1_store_len", rise_at(2) - rise_at(1), 32'd8);
        chk("s1_dreq_cycles", dreq_cnt, 32'd4);
        chk("s1_branch_pc", pc, 32'h0000_0042);
        chk("s1_retired", retired, 32'd4);
        chk("s1_halted", {31'b0, halted}, 32'd1);

        // Scenario 2: rst pulse clears halt; load with acks on the final tolerated cycle; halt third.
        hold_reset();
        chk("s2_rst_pc", pc, RST_PC);
        chk("s2_rst_halted", {31'b0, halted}, 32'd0);
        chk("s2_rst_retired", retired, 32'd0);
        prog.delete();
        prog.push_back(mk(32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0));
        prog.push_back(mk(32'h0000_2083, 1, 1, 0, 0, 0, 32'h0000_0200, 15, 15));
        prog.push_back(mk(32'h0010_0073, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0));
        build(1'b0);
        run(q.size());
        chk("s2_retired", retired, 32'd3);
        chk("s2_halted", {31'b0, halted}, 32'd1);
        chk("s2_fetches", rise.size(), 32'd3);
        chk("s2_pc", pc, 32'h0000_0008);
        chk("s2_dmem_addr", dmem_addr, 32'h0000_0200);
        chk("s2_no_fault", {31'b0, bus_err}, 32'd0);

        // Scenario 3: fetch never acknowledged.
        hold_reset();
        prog.delete();
        prog.push_back(mk(32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0));
        prog.push_back(mk(32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, -1, 0));
        build(1'b0);
        run(q.size());
        chk("s3_fault_delay", first_err - rise_at(1), 32'd16);
        chk("s3_bus_err", {31'b0, bus_err}, 32'd1);
        chk("s3_pc", pc, 32'h0000_0004);

        // Scenario 4: reset lands mid-MEM wait, then a late dmem ack.
        hold_reset();
        prog.delete();
        prog.push_back(mk(32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0));
        prog.push_back(mk(32'h0010_2023, 0, 0, 1, 0, 0, 32'h0000_0080, 0, 10));
        build(1'b0);
        run(10);
        chk("s4_dmem_req_before", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("s4_dmem_req_async", {31'b0, dmem_req}, 32'd0);
        chk("s4_pc_async", pc, RST_PC);
        chk("s4_retired_async", retired, 32'd0);
        chk("s4_dmem_addr_async", dmem_addr, 32'd0);
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;

        // Scenario 5: late dmem ack in IDLE is ignored; normal operation resumes.
        prog.delete();
        prog.push_back(mk(32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0));
        prog.push_back(mk(32'h0010_0073, 0, 0, 0, 1, 0, 32'h0000_0000, 0, 0));
        build(1'b1);
        run(q.size());
        chk("s5_retired", retired, 32'd2);
        chk("s5_pc", pc, 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
